// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: stalls the pipeline, streams one word request per
// cycle for the missing block and writes returning words and the tag into the cache arrays.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | no fill; fsm_busy follows miss_detected combinationally
//  FILL  | issuing word requests and writing returned words
//  DONE  | block complete; one cycle for the pipeline to re-look-up
module cache_fill_fsm #(
    parameter int ADDR_W          = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               miss_detected,
    input  logic [ADDR_W-1:0]                  miss_address,
    input  logic                               memory_data_valid,
    input  logic [15:0]                        memory_data,
    output logic                               fsm_busy,
    output logic                               mem_enable,
    output logic [ADDR_W-1:0]                  memory_address,
    output logic                               write_data_array,
    output logic                               write_tag_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_offset,
    output logic [15:0]                        fill_data,
    output logic [ADDR_W-1:0]                  fill_base,
    output logic                               fill_done
);

    localparam int OFF_W    = $clog2(WORDS_PER_BLOCK);
    localparam int BLK_BITS = OFF_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [OFF_W:0]      issue_cnt;
    logic [OFF_W-1:0]    recv_cnt;
    logic [ADDR_W-1:0]   fill_base_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            issue_cnt   <= '0;
            recv_cnt    <= '0;
            fill_base_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        fill_base_q <= {miss_address[ADDR_W-1:BLK_BITS], {BLK_BITS{1'b0}}};
                        issue_cnt   <= '0;
                        recv_cnt    <= '0;
                    end
                end
                FILL: begin
                    if (mem_enable) begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                    if (memory_data_valid) begin
                        recv_cnt <= recv_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt        = state;
        fsm_busy         = 1'b0;
        mem_enable       = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        word_offset      = '0;
        fill_data        = '0;
        fill_base        = '0;
        fill_done        = 1'b0;
        case (state)
            IDLE: begin
                // rst_n gates the stall so outputs stay quiet while reset is held
                fsm_busy = miss_detected & rst_n;
                if (miss_detected) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                fsm_busy  = 1'b1;
                fill_base = fill_base_q;
                if (!issue_cnt[OFF_W]) begin
                    mem_enable = 1'b1;
                    // base is block aligned, so OR-ing the offset never leaves the block
                    memory_address = fill_base_q | ADDR_W'({issue_cnt[OFF_W-1:0], 1'b0});
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    word_offset      = recv_cnt;
                    fill_data        = memory_data;
                    if (&recv_cnt) begin
                        write_tag_array = 1'b1;
                        state_nxt       = DONE;
                    end
                end
            end
            DONE: begin
                fsm_busy  = 1'b1;
                fill_base = fill_base_q;
                fill_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a transaction-level model predicts every
// output each cycle while an in-order memory model returns words after a set latency.
module tb_cache_fill_fsm;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = '0;

    logic        fsm_busy, mem_enable, write_data_array, write_tag_array, fill_done;
    logic [15:0] memory_address, fill_data, fill_base;
    logic [2:0]  word_offset;

    always #5 clk = ~clk;

    cache_fill_fsm #(.ADDR_W(16), .WORDS_PER_BLOCK(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_detected(miss_detected), .miss_address(miss_address),
        .memory_data_valid(memory_data_valid), .memory_data(memory_data),
        .fsm_busy(fsm_busy), .mem_enable(mem_enable), .memory_address(memory_address),
        .write_data_array(write_data_array), .write_tag_array(write_tag_array),
        .word_offset(word_offset), .fill_data(fill_data), .fill_base(fill_base),
        .fill_done(fill_done)
    );

    logic [55:0] obs, exp_v;
    assign obs = {fsm_busy, mem_enable, memory_address, write_data_array, write_tag_array,
                  word_offset, fill_data, fill_base, fill_done};

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // model: fill in progress, done cycle, base, cycles since fill entry, words received
    bit          m_fill = 1'b0;
    bit          m_done = 1'b0;
    logic [15:0] m_base = '0;
    int          m_k = 0;
    int          m_recv = 0;
    int          m_starts = 0;
    int          mem_lat = 1;
    logic [15:0] mem_salt = '0;

    typedef struct {
        int          due;
        logic [15:0] data;
    } resp_t;
    resp_t q[$];

    function automatic logic [15:0] data_for(input logic [15:0] a);
        return mem_salt + {13'd0, a[3:1]};
    endfunction

    task automatic drive(input logic miss, input logic [15:0] addr, input logic stray);
        logic        e_busy, e_men, e_wda, e_wta, e_done;
        logic [15:0] e_addr, e_fd, e_base;
        logic [2:0]  e_off;
        resp_t       r;
        if (!rst_n) begin
            m_fill = 1'b0;
            m_done = 1'b0;
        end
        miss_detected     = miss;
        miss_address      = addr;
        memory_data_valid = 1'b0;
        memory_data       = 16'($urandom);
        if (q.size() > 0 && q[0].due <= cyc) begin
            memory_data_valid = 1'b1;
            memory_data       = q[0].data;
            q.delete(0);
        end else if (stray && !m_fill) begin
            memory_data_valid = 1'b1;
        end
        e_busy = 0; e_men = 0; e_wda = 0; e_wta = 0; e_done = 0;
        e_addr = '0; e_fd = '0; e_base = '0; e_off = '0;
        if (rst_n) begin
            if (m_fill) begin
                e_busy = 1'b1;
                e_base = m_base;
                if (m_k < W) begin
                    e_men  = 1'b1;
                    e_addr = m_base + 16'(2 * m_k);
                    r.due  = cyc + mem_lat;
                    r.data = data_for(e_addr);
                    q.push_back(r);
                end
                if (memory_data_valid) begin
                    e_wda = 1'b1;
                    e_off = 3'(m_recv);
                    e_fd  = memory_data;
                    e_wta = (m_recv == W - 1);
                end
            end else if (m_done) begin
                e_busy = 1'b1;
                e_base = m_base;
                e_done = 1'b1;
            end else begin
                e_busy = miss;
            end
        end
        exp_v = {e_busy, e_men, e_addr, e_wda, e_wta, e_off, e_fd, e_base, e_done};
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (m_fill) begin
                m_k++;
                if (memory_data_valid) m_recv++;
                if (m_recv == W) begin
                    m_fill = 1'b0;
                    m_done = 1'b1;
                end
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (miss_detected) begin
                m_fill = 1'b1;
                m_base = miss_address & 16'hFFF0;
                m_k    = 0;
                m_recv = 0;
                m_starts++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int dones = 0;
        q.delete();
        mem_lat  = 4;
        mem_salt = 16'hA000;
        rst_n    = 1'b0;
        drive(1'b1, 16'h1236, 1'b0);
        #1;
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(i == 0, 16'h1236, 1'b0);
            #1;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL reset_fill cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
            if (fill_done === 1'b1) dones++;
            tick();
        end
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL reset_fill_done_count got=%0d exp=1", dones);
        end
    endtask

    task automatic test_top_of_memory();
        q.delete();
        mem_lat  = 1;
        mem_salt = 16'($urandom);
        for (int i = 0; i < 14; i++) begin
            drive(i == 0, 16'hFFFB, 1'b0);
            #1;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL top_of_memory cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_ignore_inputs();
        q.delete();
        mem_lat  = 3;
        mem_salt = 16'($urandom);
        for (int i = 0; i < 24; i++) begin
            if (i < 3)       drive(1'b0, 16'h4000, 1'b1);
            else if (i == 3) drive(1'b1, 16'h2468, 1'b0);
            else             drive(m_fill ? 1'($urandom_range(0, 1)) : 1'b0, 16'h4000, 1'b1);
            #1;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL ignore_inputs cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_fill();
        int writes = 0;
        q.delete();
        mem_lat  = 2;
        mem_salt = 16'($urandom);
        drive(1'b1, 16'h3450, 1'b0);
        #1;
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL midreset_start cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
        end
        tick();
        for (int i = 0; i < 30 && m_recv < 3; i++) begin
            drive(1'b0, 16'h0, 1'b0);
            #1;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL midreset_fill cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
            tick();
        end
        rst_n = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) rst_n = 1'b1;
            drive(1'b0, 16'h0, 1'b1);
            #1;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL midreset_after cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
            if (write_data_array === 1'b1 || write_tag_array === 1'b1) writes++;
            tick();
        end
        checks++;
        if (writes !== 0) begin
            failures++;
            $display("FAIL midreset_writes got=%0d exp=0", writes);
        end
        q.delete();
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        q.delete();
        mem_lat  = 2;
        mem_salt = 16'($urandom);
        m_starts = 0;
        for (int i = 0; i < 40; i++) begin
            drive(m_starts < 2, (m_starts == 0) ? 16'h0010 : 16'h0200, 1'b0);
            #1;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
            if (fill_done === 1'b1) dones++;
            tick();
        end
        checks++;
        if (dones !== 2) begin
            failures++;
            $display("FAIL back_to_back_done_count got=%0d exp=2", dones);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        q.delete();
        for (int n = 0; n < 20; n++) begin
            mem_lat  = $urandom_range(1, 5);
            mem_salt = 16'($urandom);
            a        = (n % 5 == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15))) : 16'($urandom);
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                drive(1'b0, 16'($urandom), 1'($urandom_range(0, 1)));
                #1;
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL random_gap cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
                end
                tick();
            end
            for (int i = 0; i < 17; i++) begin
                if (i == 0) drive(1'b1, a, 1'b0);
                else drive(m_fill ? 1'($urandom_range(0, 1)) : 1'b0, 16'($urandom),
                           1'($urandom_range(0, 1)));
                #1;
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL random_fill cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
                end
                tick();
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_top_of_memory();
        test_ignore_inputs();
        test_reset_mid_fill();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller between the pipelined cpu's cache arrays and a multi-cycle main memory.
- On a cache miss it stalls the pipeline and fetches the whole block by issuing one word request per cycle.
- It writes each returning word into the data array and writes the tag array on the last word.
- One instance serves the I-cache and one serves the D-cache; an arbiter outside this block selects the memory port.

Parameters:
- ADDR_W, 16, byte address width.
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; must be a power of two. Block size in bytes is 2*WORDS_PER_BLOCK.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- miss_detected  input  1  cache lookup missed this cycle.
- miss_address  input  ADDR_W  byte address of the missing access.
- memory_data_valid  input  1  memory_data holds a returned word this cycle; responses arrive in request order.
- memory_data  input  16  returned word.
- fsm_busy  output  1  stall request to the pipeline.
- mem_enable  output  1  read request to memory this cycle.
- memory_address  output  ADDR_W  address of the current request.
- write_data_array  output  1  write fill_data to the data array at word_offset.
- write_tag_array  output  1  write tag/valid for the block at fill_base.
- word_offset  output  log2(WORDS_PER_BLOCK)  word index within the block for the current data write.
- fill_data  output  16  word to write; equals memory_data.
- fill_base  output  ADDR_W  block-aligned address of the fill in progress.
- fill_done  output  1  one-cycle pulse when the block is complete.

Behaviour:
- Reset (async, rst_n=0): state IDLE; issue_cnt, recv_cnt and fill_base cleared. All outputs are 0 while in reset and in IDLE without a miss.
- States:
  - IDLE -> FILL when miss_detected=1 at the clock edge. fill_base latches miss_address with the low log2(2*WORDS_PER_BLOCK) bits cleared. issue_cnt and recv_cnt are set to 0.
  - FILL -> DONE at the edge where the last word is received, i.e. memory_data_valid=1 with recv_cnt=WORDS_PER_BLOCK-1.
  - DONE -> IDLE unconditionally after one cycle.
- fsm_busy:
  - Combinational: 1 in IDLE when miss_detected=1, so the pipeline stalls in the miss cycle itself.
  - 1 throughout FILL and DONE.
- Request issue (FILL only):
  - mem_enable=1 while issue_cnt<WORDS_PER_BLOCK.
  - memory_address = fill_base + 2*issue_cnt, modulo 2^ADDR_W.
  - issue_cnt increments each cycle mem_enable=1, giving exactly WORDS_PER_BLOCK consecutive requests beginning in the first FILL cycle.
  - memory_address=0 when mem_enable=0.
- Data receive (FILL only):
  - On memory_data_valid=1: write_data_array=1, word_offset=recv_cnt, fill_data=memory_data in the same cycle, and recv_cnt increments.
  - Memory latency is arbitrary, at least 1 cycle; the block must not depend on it.
- write_tag_array=1 in the same cycle as the final data write.
- fill_done=1 in the DONE cycle only. fsm_busy stays 1 in DONE so the re-lookup happens with the new tag. fsm_busy drops in the following IDLE cycle unless miss_detected is high again.
- Boundary cases:
  - miss_detected and miss_address are ignored in FILL/DONE; fill_base holds.
  - memory_data_valid is ignored in IDLE and DONE, so stray or late responses never write the arrays.
  - Back-to-back misses: miss_detected=1 in the IDLE cycle after DONE starts a new fill in the next cycle.
  - Reset mid-fill aborts immediately; responses still in flight after reset release are ignored.
  - fill_base=0xFFF0: the last request is 0xFFFE with no wrap into the next block. Request addresses never leave the block.
  - memory_data_valid coincident with the last issue cycle is legal and handled.

Test Plan:
- Reset with miss_detected=1 held, rst_n=0 -> all outputs 0, fsm_busy=0. Release rst_n -> fsm_busy=1 the same cycle (combinational), FILL next cycle.
- Miss at 0x1236, memory latency 4, data 0xA000+i -> mem_enable asserted for 8 consecutive cycles with addresses 0x1230..0x123E step 2. The 8 writes have word_offset 0..7 and data 0xA000..0xA007. write_tag_array pulses with the 8th write, fill_done follows one cycle later, fsm_busy is deasserted on the next cycle.
- Miss at 0xFFFB, latency 1 -> fill_base=0xFFF0, last address 0xFFFE. Completes in 1 (FILL entry) + 8 + 1 (DONE) cycles.
- During FILL, change miss_address to 0x4000 and toggle miss_detected; inject memory_data_valid pulses in IDLE -> fill_base unchanged, no array writes in IDLE.
- Assert rst_n=0 after 3 words received, then release and send 5 more valid pulses -> no further array writes, no tag write, FSM stays IDLE.
- Two misses back-to-back (0x0010 then 0x0200) -> the second fill starts the cycle after IDLE is re-entered. Both complete with correct addresses, and fill_done pulses exactly twice.
